// File: rtl/wu_memory.sv
// WU instruction memory: load-port write array, 1-cycle read into a return FIFO
// toward decode, advisory stall to fetch. Optional macro: WUM_RANGE_CHECK_EN.
module wu_memory #(
  parameter int WU_ADDR_W    = 10,
  parameter int WU_DATA_W    = 32,
  parameter int WU_DEPTH     = 1024,
  parameter int FIFO_DEPTH   = 8,
  // Keep STALL_THRESH <= FIFO_DEPTH-4 so fetch's in-flight reads still fit.
  parameter int STALL_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  input  logic                 wuf__wum__read,
  input  logic [WU_ADDR_W-1:0] wuf__wum__addr,
  output logic                 wum__wuf__stall,
  input  logic                 cfg__wum__write,
  input  logic [WU_ADDR_W-1:0] cfg__wum__addr,
  input  logic [WU_DATA_W-1:0] cfg__wum__data,
  output logic                 wum__wud__valid,
  output logic [WU_DATA_W-1:0] wum__wud__data,
  input  logic                 wud__wum__ready,
  output logic                 wum__xxx__overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   THRESH_C = CNT_W'(STALL_THRESH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [WU_ADDR_W:0] ARR_LIM  = (WU_ADDR_W + 1)'(WU_DEPTH);

  logic [WU_DATA_W-1:0] mem  [WU_DEPTH];
  logic [WU_DATA_W-1:0] fifo [FIFO_DEPTH];

  logic                 live;      // low through reset and the edge it deasserts on
  logic                 rd_pend;
  logic                 rd_oor;
  logic [WU_DATA_W-1:0] rd_word;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 do_push;
  logic                 do_pop;
  logic                 drop;
  logic [WU_DATA_W-1:0] push_data;
  logic [WU_ADDR_W-1:0] rd_idx;
  logic [WU_ADDR_W-1:0] wr_idx;
  logic                 rd_ok;
  logic                 wr_ok;

`ifdef WUM_RANGE_CHECK_EN
  assign rd_ok  = ({1'b0, wuf__wum__addr} < ARR_LIM);
  assign wr_ok  = ({1'b0, cfg__wum__addr} < ARR_LIM);
  assign rd_idx = wuf__wum__addr;
  assign wr_idx = cfg__wum__addr;
`else
  logic [WU_ADDR_W:0] rd_mod;
  logic [WU_ADDR_W:0] wr_mod;
  assign rd_mod = {1'b0, wuf__wum__addr} % ARR_LIM;
  assign wr_mod = {1'b0, cfg__wum__addr} % ARR_LIM;
  assign rd_idx = rd_mod[WU_ADDR_W-1:0];
  assign wr_idx = wr_mod[WU_ADDR_W-1:0];
  assign rd_ok  = 1'b1;
  assign wr_ok  = 1'b1;
`endif

  // Array is not reset. The read samples the old word because both updates are NBAs.
  always_ff @(posedge clk) begin
    if (live && cfg__wum__write && wr_ok) mem[wr_idx] <= cfg__wum__data;
    if (live && wuf__wum__read) rd_word <= mem[rd_idx];
  end

  // Decode handshake: a word transfers on every edge where valid and ready are
  // both high; while valid=1 and ready=0 the head word is held unchanged.
  assign do_pop    = (count != '0) && wud__wum__ready;
  assign do_push   = rd_pend && ((count != DEPTH_C) || do_pop);
  assign drop      = rd_pend && (count == DEPTH_C) && !do_pop;
  assign push_data = rd_oor ? '0 : rd_word;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      live               <= 1'b0;
      rd_pend            <= 1'b0;
      rd_oor             <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      wum__wuf__stall    <= 1'b0;
      wum__xxx__overflow <= 1'b0;
    end else begin
      live    <= 1'b1;
      rd_pend <= live && wuf__wum__read;
      rd_oor  <= live && wuf__wum__read && !rd_ok;
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count           <= count_nxt;
      wum__wuf__stall <= (count_nxt >= THRESH_C);
      if (drop || (rd_pend && rd_oor)) wum__xxx__overflow <= 1'b1;
    end
  end

  assign wum__wud__valid = (count != '0);
  assign wum__wud__data  = wum__wud__valid ? fifo[rd_ptr] : '0;

endmodule

// File: tb/tb_wu_memory.sv
// Directed bench for wu_memory: load/read latency, stall, overflow, same-cycle
// push/pop at full, read-before-write, and mid-stream reset.
module tb_wu_memory;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        rd;
  logic [9:0]  raddr;
  logic        stall;
  logic        wr;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wu_memory dut (
    .clk               (clk),
    .reset_poweron     (reset_poweron),
    .wuf__wum__read    (rd),
    .wuf__wum__addr    (raddr),
    .wum__wuf__stall   (stall),
    .cfg__wum__write   (wr),
    .cfg__wum__addr    (waddr),
    .cfg__wum__data    (wdata),
    .wum__wud__valid   (valid),
    .wum__wud__data    (data),
    .wud__wum__ready   (ready),
    .wum__xxx__overflow(ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    wr    = 1'b1;
    waddr = 10'(a);
    wdata = d;
    step();
    wr    = 1'b0;
  endtask

  // Asserts reset between edges and checks the asynchronous clear; caller releases.
  task automatic assert_reset();
    reset_poweron = 1'b0;
    #1;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_ovf",   {31'b0, ovf},   32'd0);
    chk("rst_data",  data,           32'd0);
  endtask

  initial begin
    reset_poweron = 1'b0;
    rd = 1'b0; raddr = '0; wr = 1'b0; waddr = '0; wdata = '0; ready = 1'b0;
    step();
    step();
    assert_reset();
    reset_poweron = 1'b1;
    step();

    for (int i = 0; i < 16; i++) load(i, 32'(i));
    load(5, 32'hDEAD_BEEF);
    load(7, 32'h0);

    // Read latency: valid one edge after the read is sampled.
    ready = 1'b1; rd = 1'b1; raddr = 10'd5;
    step();
    rd = 1'b0;
    chk("lat_not_yet", {31'b0, valid}, 32'd0);
    step();
    chk("lat_valid", {31'b0, valid}, 32'd1);
    chk("lat_data",  data,           32'hDEAD_BEEF);
    step();
    chk("lat_popped", {31'b0, valid}, 32'd0);

    // Stall threshold with ready low.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; raddr = 10'(i);
      step();
    end
    rd = 1'b0;
    chk("stall_cnt3", {31'b0, stall}, 32'd0);
    step();
    chk("stall_cnt4", {31'b0, stall}, 32'd1);
    chk("stall_head", data,           32'd0);
    step();
    chk("stall_hold", data, 32'd0);
    ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("stall_order", data, 32'(j));
      step();
      if (j == 0) chk("stall_fall", {31'b0, stall}, 32'd0);
    end
    chk("stall_empty", {31'b0, valid}, 32'd0);

    // Nine reads, ready low: ninth is dropped and overflow sticks.
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rd = 1'b1; raddr = 10'((i < 8) ? 8 + i : 0);
      step();
    end
    rd = 1'b0;
    chk("ovf_pre",   {31'b0, ovf},   32'd0);
    chk("ovf_stall", {31'b0, stall}, 32'd1);
    step();
    chk("ovf_set",   {31'b0, ovf},   32'd1);
    chk("ovf_valid", {31'b0, valid}, 32'd1);
    ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("ovf_order", data, 32'(8 + j));
      step();
    end
    chk("ovf_dropped", {31'b0, valid}, 32'd0);
    chk("ovf_sticky",  {31'b0, ovf},   32'd1);

    assert_reset();
    reset_poweron = 1'b1;
    step();

    // Full FIFO with simultaneous push and pop.
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rd = 1'b1; raddr = 10'((i < 8) ? 8 + i : 0);
      step();
    end
    rd = 1'b0; ready = 1'b1;
    chk("full_ovf0", {31'b0, ovf}, 32'd0);
    chk("full_head", data,         32'd8);
    step();
    chk("full_ovf1",  {31'b0, ovf},   32'd0);
    chk("full_stall", {31'b0, stall}, 32'd1);
    for (int j = 1; j < 9; j++) begin
      chk("full_order", data, 32'((j < 8) ? 8 + j : 0));
      step();
    end
    chk("full_empty", {31'b0, valid}, 32'd0);
    chk("full_ovf2",  {31'b0, ovf},   32'd0);

    // Same-cycle write and read at addr 7 returns old data.
    ready = 1'b1;
    wr = 1'b1; waddr = 10'd7; wdata = 32'h1;
    rd = 1'b1; raddr = 10'd7;
    step();
    wr = 1'b0;
    step();
    rd = 1'b0;
    chk("rbw_old", data, 32'h0);
    step();
    chk("rbw_new_valid", {31'b0, valid}, 32'd1);
    chk("rbw_new",       data,           32'h1);
    step();
    chk("rbw_empty", {31'b0, valid}, 32'd0);

    // Reset mid-stream with three entries.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; raddr = 10'(i);
      step();
    end
    rd = 1'b0;
    step();
    chk("mid_valid", {31'b0, valid}, 32'd1);
    chk("mid_head",  data,           32'd0);
    assert_reset();
    // Activity on the deassertion edge must be ignored.
    reset_poweron = 1'b1;
    rd = 1'b1; raddr = 10'd3;
    wr = 1'b1; waddr = 10'd5; wdata = 32'h55;
    step();
    rd = 1'b0; wr = 1'b0;
    step();
    chk("deassert_rd_ignored", {31'b0, valid}, 32'd0);
    ready = 1'b1; rd = 1'b1; raddr = 10'd5;
    step();
    raddr = 10'd2;
    step();
    rd = 1'b0;
    chk("keep_addr5", data, 32'hDEAD_BEEF);
    step();
    chk("keep_addr2", data, 32'd2);
    step();
    chk("keep_empty", {31'b0, valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
